// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/response bus between the fetch stage and instruction memory.
//   imem_req    fetch request, held until imem_rvalid
//   imem_addr   fetch address
//   imem_rvalid memory returns data this cycle
//   imem_rdata  returned instruction word
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V fetch stage owning the PC, fetching over a req/rvalid bus and holding the instruction until advance.
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (master)          instruction-memory request/response
//   advance               current instruction retired, fetch the next one
//   pc_src, pc_target     take pc_target instead of pc+4, sampled with advance
//   instr, op, instr_valid  held instruction, its opcode (zero when invalid), valid flag
//   pc, pc_plus4          current instruction address and its sequential successor
//   fault                 sticky misaligned-target error
module instr_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_fetch_if.master   bus,
    input  logic            advance,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fault
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, instr_n;
    logic            fault_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            instr <= instr_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = instr;
        fault_n      = fault;
        bus.imem_req = 1'b0;
        instr_valid  = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_rvalid) begin
                    instr_n = bus.imem_rdata;
                    state_n = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (advance) begin
                    // instr falls back to the NOP so it reads as "nothing valid" while the next fetch is pending
                    instr_n = NOP_INSTR;
                    if (pc_src && pc_target[1:0] != 2'b00) begin
                        fault_n = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n    = pc_src ? pc_target : pc_plus4;
                        state_n = FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.imem_addr = pc;
    assign pc_plus4      = pc + XLEN'(4);
    assign op            = instr_valid ? instr[6:0] : 7'b0000000;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized scoreboard bench for instr_fetch.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ret_t;

    logic        clk;
    logic        rst_n;
    logic        advance;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .advance     (advance),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
    );

    int          checks = 0;
    int          errors = 0;
    int          retired = 0;
    logic        mon_en = 1'b0;
    logic [31:0] addr_q[$];
    ret_t        instr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a new fetch request or a new valid instruction appears.
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.imem_req) begin
                if (!prev_req) begin
                    if (addr_q.size() == 0) chk("addr_q_empty", 1, 0);
                    else begin
                        held_addr = addr_q.pop_front();
                        chk("fetch_addr", bus.imem_addr, held_addr);
                    end
                end else chk("addr_stable", bus.imem_addr, held_addr);
                chk("wait_valid", {31'b0, instr_valid}, 0);
                chk("wait_op", {25'b0, op}, 0);
            end
            if (instr_valid && !prev_valid) begin
                if (instr_q.size() == 0) chk("instr_q_empty", 1, 0);
                else begin
                    ret_t        e;
                    logic [31:0] w;
                    e = instr_q.pop_front();
                    w = e.ins;
                    chk("ret_instr", instr, w);
                    chk("ret_pc", pc, e.pc);
                    chk("ret_op", {25'b0, op}, {25'b0, w[6:0]});
                    chk("ret_pc4", pc_plus4, e.pc + 32'd4);
                    chk("ret_fault", {31'b0, fault}, 0);
                    retired++;
                end
            end
        end
        prev_req   = mon_en && bus.imem_req;
        prev_valid = mon_en && instr_valid;
    end

    initial begin
        logic [31:0] m_pc;
        logic [31:0] rnd;
        logic [31:0] t;
        int          wait_cnt;
        rst_n = 1'b1;
        advance = 1'b0;
        pc_src = 1'b0;
        pc_target = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'b0, bus.imem_req}, 0);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_op", {25'b0, op}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0062_0233;
        chk("idle_req", {31'b0, bus.imem_req}, 0);
        tick();
        chk("first_req", {31'b0, bus.imem_req}, 1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_valid", {31'b0, instr_valid}, 0);
        tick();
        chk("v0_valid", {31'b0, instr_valid}, 1);
        chk("v0_op", {25'b0, op}, 32'h33);
        chk("v0_pc", pc, 32'h0);
        chk("v0_pc4", pc_plus4, 32'h4);
        chk("v0_instr", instr, 32'h0062_0233);
        chk("v0_req", {31'b0, bus.imem_req}, 0);
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("spur_rv_instr", instr, 32'h0062_0233);
        chk("spur_rv_valid", {31'b0, instr_valid}, 1);
        chk("spur_rv_pc", pc, 32'h0);
        bus.imem_rvalid = 1'b0;
        advance = 1'b1; pc_src = 1'b1; pc_target = 32'h40;
        tick();
        chk("jmp_addr", bus.imem_addr, 32'h40);
        chk("jmp_req", {31'b0, bus.imem_req}, 1);
        chk("jmp_pc", pc, 32'h40);
        chk("jmp_op", {25'b0, op}, 0);
        pc_target = 32'h100;
        tick();
        advance = 1'b0;
        chk("spur_adv_addr", bus.imem_addr, 32'h40);
        chk("spur_adv_req", {31'b0, bus.imem_req}, 1);
        tick();
        chk("hold_addr", bus.imem_addr, 32'h40);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0493;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("v1_pc", pc, 32'h40);
        chk("v1_instr", instr, 32'h0000_0493);
        advance = 1'b1; pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
        tick();
        advance = 1'b0;
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_006F;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("top_pc4", pc_plus4, 32'h0);
        advance = 1'b1; pc_src = 1'b0;
        tick();
        advance = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_req", {31'b0, bus.imem_req}, 1);
        chk("wrap_fault", {31'b0, fault}, 0);
        bus.imem_rvalid = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0;
        advance = 1'b1; pc_src = 1'b0;
        tick();
        advance = 1'b0;
        chk("seq_addr", bus.imem_addr, 32'h4);
        bus.imem_rvalid = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("v4_valid", {31'b0, instr_valid}, 1);
        advance = 1'b1; pc_src = 1'b1; pc_target = 32'h42;
        tick();
        chk("mis_fault", {31'b0, fault}, 1);
        chk("mis_req", {31'b0, bus.imem_req}, 0);
        chk("mis_valid", {31'b0, instr_valid}, 0);
        chk("mis_pc", pc, 32'h4);
        chk("mis_instr", instr, NOP_INSTR);
        chk("mis_op", {25'b0, op}, 0);
        for (int i = 0; i < 4; i++) begin
            advance = 1'b1; pc_src = i[0]; pc_target = 32'h80; bus.imem_rvalid = 1'b1;
            tick();
            chk("halt_pc", pc, 32'h4);
            chk("halt_req", {31'b0, bus.imem_req}, 0);
            chk("halt_valid", {31'b0, instr_valid}, 0);
            chk("halt_fault", {31'b0, fault}, 1);
        end
        advance = 1'b0; bus.imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2_fault", {31'b0, fault}, 0);
        chk("rst2_pc", pc, RESET_PC);
        tick();
        // Randomized phase: memory with random wait states, random advances/jumps and spurious inputs.
        m_pc = RESET_PC;
        addr_q.push_back(m_pc);
        wait_cnt = $urandom_range(0, 3);
        mon_en = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            advance = 1'b0;
            bus.imem_rvalid = 1'b0;
            rnd = $urandom;
            if (bus.imem_req) begin
                advance = rnd[0]; pc_src = rnd[1]; pc_target = $urandom;
                if (wait_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata = $urandom;
                    instr_q.push_back('{pc: m_pc, ins: bus.imem_rdata});
                    wait_cnt = $urandom_range(0, 3);
                end else wait_cnt--;
            end else if (instr_valid) begin
                bus.imem_rvalid = rnd[2];
                bus.imem_rdata = $urandom;
                if (rnd[4:3] != 2'b00) begin
                    advance = 1'b1;
                    pc_src = rnd[5];
                    t = $urandom;
                    t[1:0] = 2'b00;
                    if (rnd[7:6] == 2'b00) t = 32'hFFFF_FFFC;
                    pc_target = t;
                    m_pc = pc_src ? t : m_pc + 32'd4;
                    addr_q.push_back(m_pc);
                end
            end
            tick();
        end
        advance = 1'b0;
        bus.imem_rvalid = 1'b0;
        tick();
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("addr_q_drained", addr_q.size(), 0);
        chk("instr_q_drained", instr_q.size(), 0);
        chk("retired_enough", {31'b0, retired >= 40}, 1);
        tick();
        for (int i = 0; i < 4 && !bus.imem_req; i++) begin
            advance = instr_valid; pc_src = 1'b0;
            tick();
        end
        advance = 1'b0;
        chk("reach_fetch", {31'b0, bus.imem_req}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, bus.imem_req}, 0);
        chk("async_valid", {31'b0, instr_valid}, 0);
        chk("async_pc", pc, RESET_PC);
        bus.imem_rvalid = 1'b1;
        tick();
        chk("rst_rv_valid", {31'b0, instr_valid}, 0);
        chk("rst_rv_instr", instr, NOP_INSTR);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the main decoder in the RISC-V core.
- Owns the PC register and requests instructions from instruction memory through a req/rvalid handshake.
- Holds the fetched instruction stable and exposes its opcode field to the decoder until the core signals retirement.
- Computes the next PC: sequential, or the branch/jal target supplied by the datapath.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value held on instr when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory; held high until rvalid.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req is high.
- imem_rvalid  in  1  instruction memory returns data this cycle.
- imem_rdata  in  XLEN  instruction word, sampled only when imem_rvalid and imem_req are both high.
- advance  in  1  core has finished executing the current instruction; fetch the next.
- pc_src  in  1  take pc_target instead of pc+4 (branch taken / jal); sampled with advance.
- pc_target  in  XLEN  branch/jump target from the datapath adder.
- instr  out  XLEN  current instruction; NOP_INSTR when instr_valid=0.
- op  out  7  instr[6:0] when instr_valid=1, else 7'b0000000, so the decoder deasserts all control signals.
- instr_valid  out  1  instr/op/pc describe a fetched instruction.
- pc  out  XLEN  address of the current instruction.
- pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN (jal link value).
- fault  out  1  sticky misaligned-target error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, fault=0.
  - Outputs take these values immediately, without waiting for a clock edge.
- FSM states: IDLE, FETCH, VALID, HALT. All registers update on the rising clk edge.
- IDLE:
  - Unconditional transition to FETCH on the first edge after rst_n rises.
  - imem_req=0.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On an edge with imem_rvalid=1: instr<=imem_rdata, go to VALID.
  - Otherwise stay in FETCH with the request held; address stays stable.
- VALID:
  - imem_req=0, instr_valid=1; instr and pc held stable.
  - On an edge with advance=1, compute next = pc_src ? pc_target : pc+4.
    - If pc_src=1 and pc_target[1:0]!=0: fault<=1, instr<=NOP_INSTR, go to HALT, pc unchanged.
    - Otherwise pc<=next, instr<=NOP_INSTR, go to FETCH.
  - Without advance: hold indefinitely.
- HALT:
  - imem_req=0, instr_valid=0.
  - All inputs are ignored; only reset exits.
- Latency:
  - imem_rvalid sampled at edge N gives instr_valid=1 from edge N.
  - advance at edge M puts imem_req=1 with the new address from edge M.
  - Zero-wait-state memory (rvalid tied high) therefore gives one instruction per 2 cycles.
- Ignored inputs:
  - imem_rvalid outside FETCH (spurious) has no effect.
  - advance outside VALID has no effect.
  - pc_src and pc_target are sampled only with advance in VALID.
- Arithmetic: pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no fault. Only pc_target alignment is checked; sequential pc is always aligned.
- Reset asserted mid-fetch: imem_req drops asynchronously. A subsequent rvalid from memory is ignored because state is IDLE.
- Simultaneous events: advance and imem_rvalid in the same VALID cycle means advance is processed and rvalid is ignored.
- op, pc_plus4 and imem_addr are combinational from registered state; no combinational path from any input to any output.

Test Plan:
- Reset release, rvalid tied 1, rdata=32'h0062_0233:
  - imem_req=1 with addr 0 one edge after reset release.
  - instr_valid=1, op=7'b0110011, pc=0, pc_plus4=4.
- Sequential stream, rvalid delayed 3 cycles per fetch, advance pulsed with pc_src=0:
  - addresses 0,4,8,C issued in order.
  - imem_addr stable while waiting.
  - instr_valid=0 and op=0 during every wait.
- advance with pc_src=1, pc_target=32'h0000_0040:
  - next imem_addr=40, pc=40.
  - pc_target=32'h0000_0042: fault=1, state HALT, imem_req=0, pc unchanged.
  - Further advance/rvalid cause no change until reset.
- Wrap: force pc=32'hFFFF_FFFC via jump target, advance with pc_src=0 -> next imem_addr=0, fault=0.
- Reset mid-fetch: assert rst_n=0 while imem_req=1 (no clock edge) -> imem_req=0, instr_valid=0, pc=RESET_PC immediately.
- Spurious rvalid in VALID and advance in FETCH: instr, pc and state unchanged.
